// File: rtl/spike_stim_gen.sv
// Synthetic neural-signal source: baseline plus optional LFSR noise, with a biphasic
// spike template injected after a programmable interval and a ground-truth spike marker.
module spike_stim_gen #(
    parameter int          CLK_PER_SAMPLE = 1,
    parameter int          NOISE_BITS     = 6,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic signed [15:0] baseline_in,
    input  logic        [14:0] amp_in,
    input  logic        [15:0] interval_in,
    input  logic               noise_en,
    output logic               sample_valid,
    output logic signed [15:0] data_out,
    output logic               spike_marker,
    output logic        [15:0] spike_count
);
    localparam int               DIV_W    = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SAMPLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SPIKE} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   divCnt_q, divCnt_d;
    logic [15:0]        waitCnt_q, waitCnt_d;
    logic [15:0]        intervalLat_q, intervalLat_d;
    logic [14:0]        ampLat_q, ampLat_d;
    logic [2:0]         tmplIdx_q, tmplIdx_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic signed [15:0] dataOut_q, dataOut_d;
    logic               sampleValid_q, sampleValid_d;
    logic               spikeMarker_q, spikeMarker_d;
    logic [15:0]        spikeCount_q, spikeCount_d;

    logic signed [17:0] tmplVal;
    logic signed [17:0] noiseVal;
    logic signed [17:0] sum;
    logic signed [15:0] sampleSat;
    logic [15:0]        lfsrNext;

    function automatic logic signed [17:0] templateSample(input logic [2:0] idx,
                                                          input logic [14:0] a);
        logic signed [17:0] full;
        logic signed [17:0] half;
        logic signed [17:0] quarter;
        full    = signed'({3'b000, a});
        half    = signed'({4'b0000, a[14:1]});
        quarter = signed'({5'b00000, a[14:2]});
        case (idx)
            3'd1, 3'd3: templateSample = half;
            3'd2:       templateSample = full;
            3'd5:       templateSample = -half;
            3'd6:       templateSample = -quarter;
            default:    templateSample = '0;
        endcase
    endfunction

    // Sample arithmetic: template sample 0 is zero, so WAIT always adds nothing.
    always_comb begin
        tmplVal  = (state_q == S_SPIKE) ? templateSample(tmplIdx_q, ampLat_q) : '0;
        noiseVal = noise_en ? {{(18 - NOISE_BITS){lfsr_q[NOISE_BITS-1]}}, lfsr_q[NOISE_BITS-1:0]}
                            : '0;
        sum      = {{2{baseline_in[15]}}, baseline_in} + tmplVal + noiseVal;
        if (sum > 18'sd32767) begin
            sampleSat = 16'sh7FFF;
        end else if (sum < -18'sd32768) begin
            sampleSat = 16'sh8000;
        end else begin
            sampleSat = sum[15:0];
        end
        lfsrNext = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_comb begin
        state_d       = state_q;
        divCnt_d      = divCnt_q;
        waitCnt_d     = waitCnt_q;
        intervalLat_d = intervalLat_q;
        ampLat_d      = ampLat_q;
        tmplIdx_d     = tmplIdx_q;
        lfsr_d        = lfsr_q;
        dataOut_d     = dataOut_q;
        spikeCount_d  = spikeCount_q;
        sampleValid_d = 1'b0;
        spikeMarker_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                dataOut_d = '0;
                divCnt_d  = '0;
                if (enable) begin
                    intervalLat_d = interval_in;
                    waitCnt_d     = '0;
                    state_d       = S_WAIT;
                end
            end
            default: begin
                if (!enable) begin
                    state_d   = S_IDLE;
                    dataOut_d = '0;
                    divCnt_d  = '0;
                end else if (divCnt_q != DIV_LAST) begin
                    divCnt_d = divCnt_q + 1'b1;
                end else begin
                    divCnt_d      = '0;
                    sampleValid_d = 1'b1;
                    dataOut_d     = sampleSat;
                    lfsr_d        = lfsrNext;
                    if (state_q == S_WAIT) begin
                        if (waitCnt_q == intervalLat_q) begin
                            spikeMarker_d = 1'b1;
                            ampLat_d      = amp_in;
                            spikeCount_d  = spikeCount_q + 1'b1;
                            tmplIdx_d     = 3'd1;
                            state_d       = S_SPIKE;
                        end else begin
                            waitCnt_d = waitCnt_q + 1'b1;
                        end
                    end else if (tmplIdx_q == 3'd7) begin
                        state_d       = S_WAIT;
                        waitCnt_d     = '0;
                        intervalLat_d = interval_in;
                    end else begin
                        tmplIdx_d = tmplIdx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            divCnt_q      <= '0;
            waitCnt_q     <= '0;
            intervalLat_q <= '0;
            ampLat_q      <= '0;
            tmplIdx_q     <= '0;
            lfsr_q        <= LFSR_SEED;
            dataOut_q     <= '0;
            sampleValid_q <= 1'b0;
            spikeMarker_q <= 1'b0;
            spikeCount_q  <= '0;
        end else begin
            state_q       <= state_d;
            divCnt_q      <= divCnt_d;
            waitCnt_q     <= waitCnt_d;
            intervalLat_q <= intervalLat_d;
            ampLat_q      <= ampLat_d;
            tmplIdx_q     <= tmplIdx_d;
            lfsr_q        <= lfsr_d;
            dataOut_q     <= dataOut_d;
            sampleValid_q <= sampleValid_d;
            spikeMarker_q <= spikeMarker_d;
            spikeCount_q  <= spikeCount_d;
        end
    end

    assign sample_valid = sampleValid_q;
    assign data_out     = dataOut_q;
    assign spike_marker = spikeMarker_q;
    assign spike_count  = spikeCount_q;
endmodule

// File: tb/tb_spike_stim_gen.sv
// Bench for spike_stim_gen: directed tables and corner sequences plus a randomized run
// checked every clock against a sample-queue reference model.
`timescale 1ns/1ps
module tb_spike_stim_gen;
    localparam int NB = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic signed [15:0] baseline = '0;
    logic        [14:0] amp = '0;
    logic        [15:0] interval = '0;
    logic               noiseEn = 1'b0;
    logic               valid1, marker1, valid4, marker4;
    logic signed [15:0] data1, data4;
    logic        [15:0] count1, count4;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        int baseline;
        int amp;
        int interval;
        bit noiseEn;
        int expData;
        bit expMarker;
    } vec_t;

    vec_t vecs[$];
    int   pat[12]   = '{0, 0, 0, 0, 0, 500, 1000, 500, 0, -500, -250, 0};
    int   satPat[8] = '{32000, 32767, 32767, 32767, 32000, 31000, 31500, 32000};

    always #5 clk = ~clk;

    spike_stim_gen #(.CLK_PER_SAMPLE(1), .NOISE_BITS(NB), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .baseline_in(baseline), .amp_in(amp),
        .interval_in(interval), .noise_en(noiseEn), .sample_valid(valid1),
        .data_out(data1), .spike_marker(marker1), .spike_count(count1));

    spike_stim_gen #(.CLK_PER_SAMPLE(4), .NOISE_BITS(NB), .LFSR_SEED(16'hACE1)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .baseline_in(baseline), .amp_in(amp),
        .interval_in(interval), .noise_en(noiseEn), .sample_valid(valid4),
        .data_out(data4), .spike_marker(marker4), .spike_count(count4));

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: each run is a queue of pending samples (-1 = baseline, 0..7 = template).
    bit mRun;
    int mQ[$];
    int mLfsr, mAmp, mData, mCount;
    bit mValid, mMarker;

    function automatic int tmplOf(input int k, input int a);
        case (k)
            1, 3:    return a / 2;
            2:       return a;
            5:       return -(a / 2);
            6:       return -(a / 4);
            default: return 0;
        endcase
    endfunction

    function automatic int noiseOf(input int l);
        int v;
        v = l & ((1 << NB) - 1);
        if (v >= (1 << (NB - 1))) v -= (1 << NB);
        return v;
    endfunction

    task automatic refill(input int n);
        for (int i = 0; i < n; i++) mQ.push_back(-1);
        for (int k = 0; k < 8; k++) mQ.push_back(k);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        mValid  = 1'b0;
        mMarker = 1'b0;
        if (rst) begin
            mRun = 1'b0; mQ.delete(); mLfsr = 'hACE1; mAmp = 0; mData = 0; mCount = 0;
        end else if (!enable) begin
            mRun = 1'b0; mQ.delete(); mData = 0;
        end else if (!mRun) begin
            mRun = 1'b1; mQ.delete(); refill(int'(interval)); mData = 0;
        end else begin
            int e, s;
            e = mQ.pop_front();
            if (e == 0) begin
                mAmp    = int'(amp);
                mMarker = 1'b1;
                mCount  = (mCount + 1) % 65536;
            end
            s = int'(baseline) + ((e >= 0) ? tmplOf(e, mAmp) : 0) + (noiseEn ? noiseOf(mLfsr) : 0);
            mData  = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
            mValid = 1'b1;
            mLfsr  = ((mLfsr >> 1) ^ (((mLfsr & 1) != 0) ? 'hB400 : 0)) & 'hFFFF;
            if (mQ.size() == 0) refill(int'(interval));
        end
    end

    initial forever begin
        @(negedge clk);
        checkOutput("model data_out", int'(data1), mData);
        checkOutput("model sample_valid", int'(valid1), int'(mValid));
        checkOutput("model spike_marker", int'(marker1), int'(mMarker));
        checkOutput("model spike_count", int'(count1), mCount);
    end

    task automatic applyStimulus(input vec_t v);
        baseline = 16'(v.baseline);
        amp      = 15'(v.amp);
        interval = 16'(v.interval);
        noiseEn  = v.noiseEn;
        enable   = 1'b1;
    endtask

    task automatic waitTick(output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            waited++;
            seen = valid1;
        end
        if (!seen) checkOutput("tick timeout", 0, 1);
    endtask

    task automatic doReset();
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checkOutput("reset data_out", int'(data1), 0);
        checkOutput("reset sample_valid", int'(valid1), 0);
        checkOutput("reset spike_marker", int'(marker1), 0);
        checkOutput("reset spike_count", int'(count1), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic runTable(input int first, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            applyStimulus(vecs[first + i]);
            waitTick(w);
            if (i == 0) checkOutput("first tick latency", w, 2);
            checkOutput("table data_out", int'(data1), vecs[first + i].expData);
            checkOutput("table spike_marker", int'(marker1), int'(vecs[first + i].expMarker));
        end
    endtask

    initial begin
        int   w;
        int   sIdx, expLast;
        bit   expStrobe, expMark;
        vec_t v;

        for (int i = 0; i < 24; i++) begin
            v = '{0, 1000, 4, 1'b0, pat[i % 12], (i % 12) == 4};
            vecs.push_back(v);
        end
        v = '{0, 1000, 4, 1'b1, -31, 1'b0};
        vecs.push_back(v);
        v = '{0, 1000, 4, 1'b1, -16, 1'b0};
        vecs.push_back(v);
        for (int i = 0; i < 16; i++) begin
            v = '{32000, 2000, 0, 1'b0, satPat[i % 8], (i % 8) == 0};
            vecs.push_back(v);
        end

        doReset();
        runTable(0, 24);
        checkOutput("spike_count after two spikes", int'(count1), 2);

        doReset();
        runTable(24, 2);

        doReset();
        runTable(26, 16);

        // Slow-rate instance: one strobe per 4 clocks, data held in between.
        doReset();
        applyStimulus(vecs[0]);
        sIdx    = 0;
        expLast = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            expStrobe = (i >= 5) && ((i - 5) % 4 == 0);
            expMark   = 1'b0;
            if (expStrobe) begin
                expLast = pat[sIdx % 12];
                expMark = (sIdx % 12) == 4;
                sIdx++;
            end
            checkOutput("div4 sample_valid", int'(valid4), int'(expStrobe));
            checkOutput("div4 data_out", int'(data4), expLast);
            checkOutput("div4 spike_marker", int'(marker4), int'(expMark));
        end

        // Drop enable on template sample 3, then re-enable.
        doReset();
        applyStimulus(vecs[0]);
        for (int i = 0; i < 8; i++) waitTick(w);
        checkOutput("pre-drop data_out", int'(data1), 500);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("drop data_out", int'(data1), 0);
        checkOutput("drop sample_valid", int'(valid1), 0);
        checkOutput("drop spike_count", int'(count1), 1);
        @(negedge clk);
        enable = 1'b1;
        waitTick(w);
        checkOutput("re-enable latency", w, 2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) waitTick(w);
            checkOutput("re-enable data_out", int'(data1), pat[i]);
            checkOutput("re-enable spike_marker", int'(marker1), int'(i == 4));
        end
        checkOutput("re-enable spike_count", int'(count1), 2);

        // Asynchronous reset in the middle of a spike.
        doReset();
        applyStimulus(vecs[24]);
        for (int i = 0; i < 7; i++) waitTick(w);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst data_out", int'(data1), 0);
        checkOutput("async rst sample_valid", int'(valid1), 0);
        checkOutput("async rst spike_marker", int'(marker1), 0);
        checkOutput("async rst spike_count", int'(count1), 0);
        @(negedge clk);
        rst = 1'b0;
        runTable(24, 2);
        repeat (30) @(negedge clk);

        // Randomized run; the per-clock model comparison does the checking.
        doReset();
        enable = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                baseline = 16'($urandom);
                amp      = 15'($urandom);
                interval = 16'($urandom_range(0, 5));
                noiseEn  = 1'($urandom);
            end
            enable = ($urandom_range(0, 59) != 0);
            if (c == 700) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        enable = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/spike_stim_gen.md
Name: spike_stim_gen

Overview:
- Synthetic neural-signal generator, i.e. the sample-producing end of the spike detection path.
- Emits a stream of signed 16-bit samples at a programmable sample rate. Each sample is a baseline plus optional LFSR noise, with a fixed 8-sample biphasic spike template injected after a programmable inter-spike interval.
- Drives the detector's data input on-chip for self-test and bench stimulus.
- Provides a ground-truth marker and spike counter so detection latency and hit rate can be measured.

Parameters:
- CLK_PER_SAMPLE, 1, clocks per output sample (≥1); 1 gives one sample per clk.
- NOISE_BITS, 6, width of the signed noise term taken from the LFSR (1..15).
- LFSR_SEED, 16'hACE1, LFSR value after reset (must be nonzero).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run generator; low forces IDLE
- baseline_in  in  16  signed DC baseline added to every sample
- amp_in  in  15  unsigned spike amplitude, latched at spike start
- interval_in  in  16  unsigned baseline samples between spikes, latched on WAIT entry
- noise_en  in  1  add LFSR noise when high
- sample_valid  out  1  one-clk strobe; data_out is new on this cycle
- data_out  out  16  signed output sample
- spike_marker  out  1  high with sample_valid on template sample 0
- spike_count  out  16  number of spikes started; wraps 65535→0

Behaviour:
- Reset (async): data_out=0, sample_valid=0, spike_marker=0, spike_count=0, state=IDLE, lfsr=LFSR_SEED, all counters 0.
- All outputs are registered.
- Tick: div_cnt runs only in WAIT/SPIKE. A tick occurs on the edge where div_cnt==CLK_PER_SAMPLE-1; div_cnt then returns to 0, otherwise it increments.
- On a tick: sample_valid=1 and data_out/spike_marker are updated. Between ticks, sample_valid=0, spike_marker=0, and data_out holds.
- States:
  - IDLE: data_out=0, div_cnt=0. If enable=1: latch interval_in, wait_cnt=0, go WAIT.
  - WAIT, on tick: if wait_cnt==interval_lat, emit template[0], spike_marker=1, latch amp_in, spike_count+1, tmpl_idx=1, go SPIKE. Otherwise emit baseline sample and wait_cnt+1.
  - SPIKE, on tick: emit template[tmpl_idx]. If tmpl_idx==7: go WAIT, wait_cnt=0, latch interval_in. Otherwise tmpl_idx+1.
  - enable=0 in any state: on the next edge go IDLE, data_out=0, strobes 0. A spike in progress is abandoned; spike_count is not decremented. LFSR is not reseeded.
- First tick after enable: with CLK_PER_SAMPLE=1, sample_valid first asserts 2 edges after the edge that samples enable=1 (IDLE→WAIT, then tick).
- Template T[k] (A=amp_lat): 0, A>>1, A, A>>1, 0, -(A>>1), -(A>>2), 0. Shifts truncate.
- Noise N: if noise_en, sign-extended lfsr[NOISE_BITS-1:0] using the LFSR value before advance; else 0.
- LFSR advances on every tick regardless of noise_en: Galois right shift, lfsr = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- Arithmetic: sum = baseline_in + T + N in 18-bit signed, saturated to [-32768, 32767]. Baseline samples use T=0.
- baseline_in and noise_en are sampled live at each tick.
- interval_in=0: spikes back-to-back, 8-sample period, marker every 8 ticks.
- amp_in/interval_in changes mid-spike or mid-wait take effect only at the next latch point.

Test Plan:
- CLK_PER_SAMPLE=1, baseline=0, amp=1000, interval=4, noise off, enable=1 → data_out per tick 0,0,0,0,0,500,1000,500,0,-500,-250,0, then repeats; marker on tick 5 and tick 17; spike_count 1 then 2.
- Same settings, noise_en=1 from reset → first two ticks 0+(-31)=-31 and -16 (LFSR 0xACE1→0xE270).
- baseline=32000, amp=2000, interval=0 → per spike: 32000, 32767, 32767, 32767, 32000, 31000, 31500, 32000; no wraparound.
- CLK_PER_SAMPLE=4 → sample_valid exactly once every 4 clks; data_out stable between strobes.
- enable dropped at template sample 3 → next edge data_out=0, sample_valid=0, state IDLE. Re-enable → full interval of baseline before the next marker; spike_count continues.
- rst asserted mid-SPIKE, asynchronously → all outputs 0 immediately; after release with enable=1, the sequence restarts identically to the first test, including noise sequence.
